// File: rtl/inst_prefetch_pkg.sv
// Shared CPU types for the prefetch slice:
// widths, NOP encoding, FSM states, queue entry.
package cpu_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INST = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } pf_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } pf_entry_t;

  function automatic logic [XLEN-1:0] dw_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:3], 3'b000};
  endfunction
endpackage

// File: rtl/inst_prefetch_if.sv
// Fetch-side bus between prefetcher (master)
// and memory controller (slave).
interface inst_prefetch_if;
  import cpu_pkg::*;

  logic [XLEN-1:0] HADDR;
  logic            HTRANS;
  logic [XLEN-1:0] HRDATA;
  logic            bus_stall;

  modport master (
    output HADDR, HTRANS,
    input  HRDATA, bus_stall
  );

  modport slave (
    input  HADDR, HTRANS,
    output HRDATA, bus_stall
  );
endinterface

// File: rtl/prefetch_fifo.sv
// Instruction queue: two write ports, one read
// port, flush, occupancy count.
module prefetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [1:0]             push_cnt,
  input  pf_entry_t              wdata0,
  input  pf_entry_t              wdata1,
  input  logic                   pop,
  output pf_entry_t              rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pf_entry_t     mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  // pointer arithmetic wraps naturally at DEPTH
  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0)
      mem[tail] <= wdata0;
    if (push_cnt == 2'd2)
      mem[tail + AW'(1)] <= wdata1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + AW'(push_cnt);
      if (pop)
        head <= head + AW'(1);
      count <= count + CW'(push_cnt) - CW'(pop);
    end
  end

  assign rdata = mem[head];
endmodule

// File: rtl/inst_prefetch.sv
// Decoupled prefetcher: sequential 64-bit fetch,
// split into 32-bit instructions, queued for decode.
module inst_prefetch
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  inst_prefetch_if.master bus,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid
);
  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_t       state;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   count;
  logic            room;
  logic            accept;
  logic            pop;
  logic [1:0]      push_cnt;
  pf_entry_t       w0;
  pf_entry_t       w1;
  pf_entry_t       head;

  // conservative: ignores this cycle's pop
  assign room = (CW'(DEPTH) - count) >= CW'(2);

  assign bus.HTRANS = (state == FETCH) && room;
  assign bus.HADDR  = dw_align(fetch_pc);

  assign accept = bus.HTRANS && !bus.bus_stall
                  && !redirect;
  assign push_cnt = !accept    ? 2'd0 :
                    fetch_pc[2] ? 2'd1 : 2'd2;

  assign inst_valid = count != '0;
  assign pop = inst_valid && !stall && !redirect;

  always_comb begin
    w0.pc   = fetch_pc;
    w0.inst = fetch_pc[2] ? bus.HRDATA[63:32]
                          : bus.HRDATA[31:0];
    w1.pc   = fetch_pc + XLEN'(4);
    w1.inst = bus.HRDATA[63:32];
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      state    <= FETCH;
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      unique case (state)
        IDLE:    state <= FETCH;
        FETCH:   if (!room) state <= HOLD;
        HOLD:    if (room) state <= FETCH;
        default: state <= IDLE;
      endcase
      if (accept)
        fetch_pc <= fetch_pc +
          (fetch_pc[2] ? XLEN'(4) : XLEN'(8));
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst_n   (RESET),
    .flush   (redirect),
    .push_cnt(push_cnt),
    .wdata0  (w0),
    .wdata1  (w1),
    .pop     (pop),
    .rdata   (head),
    .count   (count)
  );

  assign inst    = inst_valid ? head.inst : NOP_INST;
  assign inst_pc = inst_valid ? head.pc : '0;
endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: bus monitor feeds an
// expected-PC queue, drained as decode pops.
module tb_inst_prefetch;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic        CLK = 0;
  logic        RESET = 0;
  logic        redirect = 0;
  logic [63:0] redirect_pc = '0;
  logic        stall = 0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_q[$];
  logic [63:0] model_pc = '0;

  inst_prefetch_if bus();

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(
    input logic [63:0] a
  );
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  assign bus.HRDATA = {mem_word(bus.HADDR + 64'd4),
                       mem_word(bus.HADDR)};

  inst_prefetch #(
    .DEPTH(DEPTH),
    .RESET_PC(64'h0)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .bus        (bus),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // monitor: sample mid-cycle, predict the next edge
  always @(negedge CLK) begin
    logic [63:0] pc;
    check("valid", inst_valid, exp_q.size() != 0);
    check("count", 64'(dut.u_fifo.count),
          64'(exp_q.size()));
    if (exp_q.size() == 0) begin
      check("nop", inst, NOP_INST);
      check("pc0", inst_pc, 64'h0);
    end
    if (RESET && !redirect) begin
      if (inst_valid && !stall && exp_q.size() != 0) begin
        pc = exp_q.pop_front();
        check("inst_pc", inst_pc, pc);
        check("inst", inst, mem_word(pc));
      end
      if (bus.HTRANS && !bus.bus_stall) begin
        check("haddr", bus.HADDR,
              {model_pc[63:3], 3'b000});
        exp_q.push_back(model_pc);
        if (!model_pc[2])
          exp_q.push_back(model_pc + 64'd4);
        model_pc = model_pc +
          (model_pc[2] ? 64'd4 : 64'd8);
      end
    end
    if (!RESET) begin
      exp_q.delete();
      model_pc = '0;
    end else if (redirect) begin
      exp_q.delete();
      model_pc = {redirect_pc[63:2], 2'b00};
    end
  end

  task automatic redir_lat(
    input logic [63:0] tgt,
    input logic [63:0] first
  );
    redirect    = 1;
    redirect_pc = tgt;
    tick();
    redirect = 0;
    check("rd_v0", inst_valid, 1'b0);
    check("rd_req", bus.HTRANS, 1'b1);
    tick();
    check("rd_v1", inst_valid, 1'b1);
    check("rd_pc", inst_pc, first);
    tick(5);
  endtask

  initial begin
    int n;
    bit hit;
    bus.bus_stall = 0;

    tick(3);
    check("rst_req", bus.HTRANS, 1'b0);
    check("rst_addr", bus.HADDR, 64'h0);
    check("rst_v", inst_valid, 1'b0);
    check("rst_inst", inst, NOP_INST);
    check("rst_pc", inst_pc, 64'h0);
    check("rst_st", 64'(dut.state), 64'(IDLE));

    RESET = 1;
    tick();
    check("req_c2", bus.HTRANS, 1'b1);
    tick();
    n = 0;
    repeat (16) begin
      if (inst_valid)
        n++;
      tick();
    end
    check("rate", n, 16);

    redirect    = 1;
    redirect_pc = 64'h200;
    stall       = 1;
    tick();
    redirect = 0;
    tick(9);
    check("bp_cnt", 64'(dut.u_fifo.count), 64'd4);
    check("bp_st", 64'(dut.state), 64'(HOLD));
    check("bp_req", bus.HTRANS, 1'b0);
    stall = 0;
    tick(12);

    redirect      = 1;
    redirect_pc   = 64'h10;
    bus.bus_stall = 1;
    tick();
    redirect = 0;
    for (int i = 0; i < 3; i++) begin
      check("bs_addr", bus.HADDR, 64'h10);
      check("bs_req", bus.HTRANS, 1'b1);
      check("bs_v", inst_valid, 1'b0);
      tick();
    end
    bus.bus_stall = 0;
    tick();
    check("bs_pc", inst_pc, 64'h10);
    tick(6);

    redir_lat(64'h104, 64'h104);
    redir_lat(64'h106, 64'h104);

    hit = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.HTRANS && inst_valid) begin
        hit = 1;
        break;
      end
      tick();
    end
    check("col_wait", hit, 1'b1);
    redirect    = 1;
    redirect_pc = 64'h300;
    tick();
    redirect = 0;
    check("col_cnt", 64'(dut.u_fifo.count), 64'd0);
    tick();
    check("col_pc", inst_pc, 64'h300);
    tick(4);

    repeat (50) begin
      stall         = 1'($urandom_range(0, 1));
      bus.bus_stall = ($urandom_range(0, 3) == 0);
      tick($urandom_range(1, 3));
    end
    stall         = 0;
    bus.bus_stall = 0;
    tick(10);

    RESET = 0;
    tick();
    check("mr_v", inst_valid, 1'b0);
    check("mr_req", bus.HTRANS, 1'b0);
    check("mr_st", 64'(dut.state), 64'(IDLE));
    RESET = 1;
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want done");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/inst_prefetch.md
# inst_prefetch

Decoupled instruction prefetcher sitting between the memory controller's fetch master port and `inst_decode`. It issues sequential 64-bit fetches, splits each doubleword into two 32-bit instructions, and buffers them with their PCs in a small queue. `inst_decode` drains the queue under `stall` back-pressure, so bus arbitration bubbles are hidden from decode. A redirect from a branch or jump flushes the queue and restarts fetch at the new PC.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥ 2.
- `RESET_PC`, 64'h0: first fetch address after reset; 8-byte aligned.

Ports:
- `CLK`  in  1  clock; all state updates on posedge.
- `RESET`  in  1  reset; synchronous, active-low.
- `HADDR`  out  64  fetch address, always 8-byte aligned.
- `HTRANS`  out  1  fetch request valid.
- `HRDATA`  in  64  read data; valid in the same cycle as an accepted request.
- `bus_stall`  in  1  controller has not granted this cycle; hold the request.
- `redirect`  in  1  flush the queue and restart fetch.
- `redirect_pc`  in  64  new fetch PC; bits [1:0] ignored.
- `stall`  in  1  decode cannot accept; no pop this cycle.
- `inst`  out  32  head instruction; `32'h00000013` (NOP) when the queue is empty.
- `inst_pc`  out  64  PC of the head instruction; 0 when the queue is empty.
- `inst_valid`  out  1  head entry present.

## Operation
- `fetch_pc` is 64 bits. `HADDR = {fetch_pc[63:3], 3'b0}`.
- Accept condition: `HTRANS && !bus_stall`. On accept, data is captured at the posedge.
- Little-endian split of the captured doubleword:
  - `HRDATA[31:0]` is the instruction at `HADDR`.
  - `HRDATA[63:32]` is the instruction at `HADDR+4`.
  - If `fetch_pc[2]=1`, push only the upper word and advance by 4.
  - Otherwise push both words, lower word first, and advance by 8.
- Pop: when `inst_valid && !stall`, exactly one entry is removed per cycle.
- `count` width is `$clog2(DEPTH)+1`. Each cycle, `count_next = count + pushed - popped`, with `pushed` in {0,1,2}.
- FSM:
  - **IDLE**: entered on reset; lasts one cycle; `HTRANS=0`. Always goes to FETCH.
  - **FETCH**: `HTRANS=1`.
    - If `DEPTH - count < 2`, raise no request and go to HOLD.
    - The free-slot check uses `count` before this cycle's pop, so it is conservative.
  - **HOLD**: `HTRANS=0`. Return to FETCH once `DEPTH - count ≥ 2`.
  - `bus_stall` keeps FETCH asserted, with `HADDR` held, until the request is accepted.
- Redirect, allowed in any state, has priority over push and pop in the same cycle:
  - `count`, head and tail reset to 0.
  - Same-cycle fetch data is discarded.
  - `fetch_pc <= {redirect_pc[63:2], 2'b00}`.
  - Next state is FETCH, including when the current state is IDLE.
- Pointers wrap modulo `DEPTH`. A 2-entry push may straddle the wrap.
- Overflow never occurs, by construction. Underflow never occurs, because a pop requires `inst_valid`.

## Timing
- Reset values: `HTRANS=0`, `HADDR={RESET_PC[63:3],3'b0}`, `inst_valid=0`, `inst=32'h00000013`, `inst_pc=0`, `fetch_pc=RESET_PC`, state IDLE.
- Request accepted at posedge N → `inst_valid=1` from cycle N+1. There is no same-cycle bypass.
- Minimum redirect-to-`inst_valid` latency: 1 cycle of request + 1 cycle, i.e. 2 cycles when there is no `bus_stall`.
- Steady state with `stall=0`: 1 instruction per cycle. Fetch bandwidth (2 per accepted request) exceeds demand.
- `RESET` low mid-operation discards all state at the next posedge.

## Structure
- Shared package `cpu_pkg` holds:
  - `NOP_INST = 32'h00000013`
  - FSM state encoding `{IDLE, FETCH, HOLD}`
  - `XLEN = 64`, `ILEN = 32`
- Sub-module `prefetch_fifo` contains:
  - `DEPTH` entries of `{pc[63:0], inst[31:0]}`
  - 2-write / 1-read ports, `flush`, and `count`
- FSM and PC logic live in `inst_prefetch`.

## Test plan
- **Reset and steady state.** Hold `RESET` low, then release; `RESET_PC=0`, memory holds sequential words, `stall=0`, `bus_stall=0`.
  - `HTRANS` rises in the second cycle after release.
  - `inst_pc` then reads 0, 4, 8, 12, … at one per cycle.
- **Back-pressure.** Hold `stall=1` for 10 cycles with `DEPTH=4`.
  - `count` saturates at 4 and the FSM enters HOLD with `HTRANS=0`.
  - On release, pops resume and no instruction is lost or duplicated.
- **Bus stall.** Assert `bus_stall=1` for 3 cycles with `HADDR=0x10`.
  - `HADDR` stays stable and no push occurs.
  - After release, entries 0x10 and 0x14 appear.
- **Misaligned redirect.** Redirect to `0x104`.
  - Queue flushed.
  - First `inst_pc=0x104` (single push), then 0x108, 0x10C.
  - A redirect to `0x106` behaves identically.
- **Redirect collisions.** Assert redirect in the same cycle as an accepted fetch and a pop.
  - Fetched data is dropped.
  - `count=0` on the next cycle.
  - Next `inst_pc` equals the redirect target.
- **Wrap-around.** Run 50 random `stall` patterns with `DEPTH=4`.
  - The output PC sequence is strictly +4 between redirects.
  - `count ≤ 4` at all times.
